// File: rtl/register_array_pipelined_tagged_pkg.sv
// Shared types and constants for the tagged register-array priority queue.
// Op codes, sort phase and the settle threshold live here so bench and RTL agree.
package register_array_pipelined_tagged_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ENQ,
    OP_DEQ,
    OP_REPL,
    OP_FLUSH
  } op_e;

  typedef enum logic {
    PH_EVEN,
    PH_ODD
  } phase_e;

  localparam int SETTLE_CYCLES = 2;
  localparam int QUIET_W       = $clog2(SETTLE_CYCLES + 1);

endpackage

// File: rtl/register_array_pipelined_tagged_cmp_swap.sv
// Compare-and-swap cell for one entry pair: the better-ranked entry leaves on hi.
// Valid outranks invalid; equal keys and two invalid entries stay in place.
module ra_cmp_swap #(
  parameter int KEY_WIDTH = 16,
  parameter int TAG_WIDTH = 8,
  parameter int MAX_FIRST = 1
) (
  input  logic                 a_valid,
  input  logic [KEY_WIDTH-1:0] a_key,
  input  logic [TAG_WIDTH-1:0] a_tag,
  input  logic                 b_valid,
  input  logic [KEY_WIDTH-1:0] b_key,
  input  logic [TAG_WIDTH-1:0] b_tag,
  output logic                 hi_valid,
  output logic [KEY_WIDTH-1:0] hi_key,
  output logic [TAG_WIDTH-1:0] hi_tag,
  output logic                 lo_valid,
  output logic [KEY_WIDTH-1:0] lo_key,
  output logic [TAG_WIDTH-1:0] lo_tag,
  output logic                 swapped
);

  logic b_wins;

  always_comb begin
    b_wins = 1'b0;
    if (b_valid && !a_valid) begin
      b_wins = 1'b1;
    end else if (b_valid && a_valid) begin
      b_wins = (MAX_FIRST != 0) ? (b_key > a_key) : (b_key < a_key);
    end
  end

  always_comb begin
    hi_valid = a_valid;
    hi_key   = a_key;
    hi_tag   = a_tag;
    lo_valid = b_valid;
    lo_key   = b_key;
    lo_tag   = b_tag;
    if (b_wins) begin
      hi_valid = b_valid;
      hi_key   = b_key;
      hi_tag   = b_tag;
      lo_valid = a_valid;
      lo_key   = a_key;
      lo_tag   = a_tag;
    end
  end

  assign swapped = b_wins;

endmodule

// File: rtl/register_array_pipelined_tagged.sv
// Tagged priority queue held in a register array, kept ordered by an
// odd-even transposition sort that runs one phase per cycle behind the ops.
module register_array_pipelined_tagged
  import register_array_pipelined_tagged_pkg::*;
#(
  parameter int QUEUE_SIZE = 8,
  parameter int KEY_WIDTH  = 16,
  parameter int TAG_WIDTH  = 8,
  parameter int MAX_FIRST  = 1,
  parameter int ENQ_ENA    = 1
) (
  input  logic                          i_CLK,
  input  logic                          i_RSTn,
  input  logic                          i_flush,
  input  logic                          i_wrt,
  input  logic                          i_read,
  input  logic [KEY_WIDTH-1:0]          i_key,
  input  logic [TAG_WIDTH-1:0]          i_tag,
  output logic [KEY_WIDTH-1:0]          o_key,
  output logic [TAG_WIDTH-1:0]          o_tag,
  output logic                          o_head_valid,
  output logic [$clog2(QUEUE_SIZE):0]   o_count,
  output logic                          o_full,
  output logic                          o_empty,
  output logic                          o_overflow,
  output logic                          o_underflow,
  output logic                          o_settled
);

  localparam int CW = $clog2(QUEUE_SIZE) + 1;
  localparam int NE = QUEUE_SIZE / 2;
  localparam int NO = QUEUE_SIZE / 2 - 1;
  localparam logic [QUIET_W-1:0] QUIET_MAX = QUIET_W'(SETTLE_CYCLES);

  // Registered array state
  logic                 vld_q [QUEUE_SIZE];
  logic [KEY_WIDTH-1:0] key_q [QUEUE_SIZE];
  logic [TAG_WIDTH-1:0] tag_q [QUEUE_SIZE];
  logic [CW-1:0]        count_q;
  phase_e               phase_q;
  logic [QUIET_W-1:0]   quiet_q;
  logic                 overflow_q;
  logic                 underflow_q;

  // Post-op array, then the two candidate sort results
  logic                 p_vld [QUEUE_SIZE];
  logic [KEY_WIDTH-1:0] p_key [QUEUE_SIZE];
  logic [TAG_WIDTH-1:0] p_tag [QUEUE_SIZE];
  logic                 e_vld [QUEUE_SIZE];
  logic [KEY_WIDTH-1:0] e_key [QUEUE_SIZE];
  logic [TAG_WIDTH-1:0] e_tag [QUEUE_SIZE];
  logic                 d_vld [QUEUE_SIZE];
  logic [KEY_WIDTH-1:0] d_key [QUEUE_SIZE];
  logic [TAG_WIDTH-1:0] d_tag [QUEUE_SIZE];
  logic                 e_sw  [NE];
  logic                 d_sw  [NO];

  op_e           op;
  logic          is_full;
  logic          is_empty;
  logic          accepted;
  logic          ovf_d;
  logic          udf_d;
  logic          swap_any;
  int            free_idx;
  logic [CW-1:0] count_d;

  assign is_full  = (count_q == CW'(QUEUE_SIZE));
  assign is_empty = (count_q == '0);

  // A replace with nothing to replace is treated as an insertion.
  always_comb begin
    op = OP_NONE;
    if (i_flush) begin
      op = OP_FLUSH;
    end else if (i_wrt && !i_read && (ENQ_ENA != 0)) begin
      op = OP_ENQ;
    end else if (!i_wrt && i_read) begin
      op = OP_DEQ;
    end else if (i_wrt && i_read) begin
      op = is_empty ? OP_ENQ : OP_REPL;
    end
  end

  always_comb begin
    accepted = (op == OP_FLUSH) || (op == OP_REPL) ||
               ((op == OP_ENQ) && !is_full) || ((op == OP_DEQ) && !is_empty);
    ovf_d    = (op == OP_ENQ) && is_full;
    udf_d    = (op == OP_DEQ) && is_empty;
  end

  always_comb begin
    free_idx = QUEUE_SIZE - 1;
    for (int i = QUEUE_SIZE - 1; i >= 0; i--) begin
      if (!vld_q[i]) free_idx = i;
    end
  end

  always_comb begin
    p_vld   = vld_q;
    p_key   = key_q;
    p_tag   = tag_q;
    count_d = count_q;
    case (op)
      OP_FLUSH: begin
        for (int i = 0; i < QUEUE_SIZE; i++) begin
          p_vld[i] = 1'b0;
          p_key[i] = '0;
          p_tag[i] = '0;
        end
        count_d = '0;
      end
      OP_ENQ: begin
        if (!is_full) begin
          // Entries ahead of the first hole slide down one slot to make room at the head.
          for (int i = 1; i < QUEUE_SIZE; i++) begin
            if (i <= free_idx) begin
              p_vld[i] = vld_q[i-1];
              p_key[i] = key_q[i-1];
              p_tag[i] = tag_q[i-1];
            end
          end
          p_vld[0] = 1'b1;
          p_key[0] = i_key;
          p_tag[0] = i_tag;
          count_d  = count_q + CW'(1);
        end
      end
      OP_DEQ: begin
        if (!is_empty) begin
          p_vld[0] = 1'b0;
          p_key[0] = '0;
          p_tag[0] = '0;
          count_d  = count_q - CW'(1);
        end
      end
      OP_REPL: begin
        p_vld[0] = 1'b1;
        p_key[0] = i_key;
        p_tag[0] = i_tag;
      end
      default: ;
    endcase
  end

  for (genvar j = 0; j < NE; j++) begin : g_even
    ra_cmp_swap #(
      .KEY_WIDTH (KEY_WIDTH),
      .TAG_WIDTH (TAG_WIDTH),
      .MAX_FIRST (MAX_FIRST)
    ) u_cs (
      .a_valid  (p_vld[2*j]),
      .a_key    (p_key[2*j]),
      .a_tag    (p_tag[2*j]),
      .b_valid  (p_vld[2*j+1]),
      .b_key    (p_key[2*j+1]),
      .b_tag    (p_tag[2*j+1]),
      .hi_valid (e_vld[2*j]),
      .hi_key   (e_key[2*j]),
      .hi_tag   (e_tag[2*j]),
      .lo_valid (e_vld[2*j+1]),
      .lo_key   (e_key[2*j+1]),
      .lo_tag   (e_tag[2*j+1]),
      .swapped  (e_sw[j])
    );
  end

  // The odd phase leaves the two end slots untouched.
  assign d_vld[0]            = p_vld[0];
  assign d_key[0]            = p_key[0];
  assign d_tag[0]            = p_tag[0];
  assign d_vld[QUEUE_SIZE-1] = p_vld[QUEUE_SIZE-1];
  assign d_key[QUEUE_SIZE-1] = p_key[QUEUE_SIZE-1];
  assign d_tag[QUEUE_SIZE-1] = p_tag[QUEUE_SIZE-1];

  for (genvar j = 0; j < NO; j++) begin : g_odd
    ra_cmp_swap #(
      .KEY_WIDTH (KEY_WIDTH),
      .TAG_WIDTH (TAG_WIDTH),
      .MAX_FIRST (MAX_FIRST)
    ) u_cs (
      .a_valid  (p_vld[2*j+1]),
      .a_key    (p_key[2*j+1]),
      .a_tag    (p_tag[2*j+1]),
      .b_valid  (p_vld[2*j+2]),
      .b_key    (p_key[2*j+2]),
      .b_tag    (p_tag[2*j+2]),
      .hi_valid (d_vld[2*j+1]),
      .hi_key   (d_key[2*j+1]),
      .hi_tag   (d_tag[2*j+1]),
      .lo_valid (d_vld[2*j+2]),
      .lo_key   (d_key[2*j+2]),
      .lo_tag   (d_tag[2*j+2]),
      .swapped  (d_sw[j])
    );
  end

  always_comb begin
    swap_any = 1'b0;
    if (phase_q == PH_EVEN) begin
      for (int j = 0; j < NE; j++) swap_any = swap_any | e_sw[j];
    end else begin
      for (int j = 0; j < NO; j++) swap_any = swap_any | d_sw[j];
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        vld_q[i] <= 1'b0;
        key_q[i] <= '0;
        tag_q[i] <= '0;
      end
      count_q     <= '0;
      phase_q     <= PH_EVEN;
      quiet_q     <= QUIET_MAX;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        vld_q[i] <= (phase_q == PH_EVEN) ? e_vld[i] : d_vld[i];
        key_q[i] <= (phase_q == PH_EVEN) ? e_key[i] : d_key[i];
        tag_q[i] <= (phase_q == PH_EVEN) ? e_tag[i] : d_tag[i];
      end
      count_q     <= count_d;
      overflow_q  <= ovf_d;
      underflow_q <= udf_d;
      if (op == OP_FLUSH) begin
        phase_q <= PH_EVEN;
      end else begin
        phase_q <= (phase_q == PH_EVEN) ? PH_ODD : PH_EVEN;
      end
      if (accepted || swap_any) begin
        quiet_q <= '0;
      end else if (quiet_q != QUIET_MAX) begin
        quiet_q <= quiet_q + QUIET_W'(1);
      end
    end
  end

  assign o_key        = key_q[0];
  assign o_tag        = tag_q[0];
  assign o_head_valid = vld_q[0];
  assign o_count      = count_q;
  assign o_full       = is_full;
  assign o_empty      = is_empty;
  assign o_overflow   = overflow_q;
  assign o_underflow  = underflow_q;
  assign o_settled    = (quiet_q == QUIET_MAX);

endmodule

// File: tb/tb_register_array_pipelined_tagged.sv
// Bench for the tagged priority queue: a max-first and a min-first instance share
// stimulus; a multiset model per instance supplies expected heads, counts and pulses.
module tb_register_array_pipelined_tagged;

  localparam int QS = 4;
  localparam int KW = 16;
  localparam int TW = 8;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic flush, wrt, rd;
  logic [KW-1:0] key_in;
  logic [TW-1:0] tag_in;

  // index 0: max-first instance, index 1: min-first instance
  logic [KW-1:0] o_key   [2];
  logic [TW-1:0] o_tag   [2];
  logic          o_hv    [2];
  logic [CW-1:0] o_count [2];
  logic          o_full  [2];
  logic          o_empty [2];
  logic          o_ovf   [2];
  logic          o_udf   [2];
  logic          o_set   [2];

  int n_vec = 0;
  int n_err = 0;

  bit            mdl_vld [2][QS];
  logic [KW-1:0] mdl_key [2][QS];
  logic [TW-1:0] mdl_tag [2][QS];
  int            mdl_n   [2];
  logic [KW+TW-1:0] exp_q[$];

  always #5 clk = ~clk;

  register_array_pipelined_tagged #(
    .QUEUE_SIZE (QS), .KEY_WIDTH (KW), .TAG_WIDTH (TW), .MAX_FIRST (1), .ENQ_ENA (1)
  ) dut_max (
    .i_CLK (clk), .i_RSTn (rst_n), .i_flush (flush), .i_wrt (wrt), .i_read (rd),
    .i_key (key_in), .i_tag (tag_in), .o_key (o_key[0]), .o_tag (o_tag[0]),
    .o_head_valid (o_hv[0]), .o_count (o_count[0]), .o_full (o_full[0]),
    .o_empty (o_empty[0]), .o_overflow (o_ovf[0]), .o_underflow (o_udf[0]),
    .o_settled (o_set[0])
  );

  register_array_pipelined_tagged #(
    .QUEUE_SIZE (QS), .KEY_WIDTH (KW), .TAG_WIDTH (TW), .MAX_FIRST (0), .ENQ_ENA (1)
  ) dut_min (
    .i_CLK (clk), .i_RSTn (rst_n), .i_flush (flush), .i_wrt (wrt), .i_read (rd),
    .i_key (key_in), .i_tag (tag_in), .o_key (o_key[1]), .o_tag (o_tag[1]),
    .o_head_valid (o_hv[1]), .o_count (o_count[1]), .o_full (o_full[1]),
    .o_empty (o_empty[1]), .o_overflow (o_ovf[1]), .o_underflow (o_udf[1]),
    .o_settled (o_set[1])
  );

  // ---------------- model ----------------
  function automatic int best_idx(input int s);
    int b = -1;
    for (int i = 0; i < QS; i++) begin
      if (mdl_vld[s][i]) begin
        if (b < 0) b = i;
        else if (s == 0 && mdl_key[s][i] > mdl_key[s][b]) b = i;
        else if (s == 1 && mdl_key[s][i] < mdl_key[s][b]) b = i;
      end
    end
    return b;
  endfunction

  task automatic mdl_add(input int s, input logic [KW-1:0] k, input logic [TW-1:0] t);
    bit done = 0;
    for (int i = 0; i < QS; i++) begin
      if (!done && !mdl_vld[s][i]) begin
        mdl_vld[s][i] = 1; mdl_key[s][i] = k; mdl_tag[s][i] = t; done = 1;
      end
    end
    mdl_n[s]++;
  endtask

  task automatic mdl_clear();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < QS; i++) mdl_vld[s][i] = 0;
      mdl_n[s] = 0;
    end
  endtask

  function automatic bit key_used(input logic [KW-1:0] k);
    bit u = 0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < QS; i++)
        if (mdl_vld[s][i] && mdl_key[s][i] == k) u = 1;
    return u;
  endfunction

  function automatic logic [KW-1:0] fresh_key();
    logic [KW-1:0] k;
    do k = KW'($urandom_range(1, 60000)); while (key_used(k));
    return k;
  endfunction

  // ---------------- drivers ----------------
  task automatic apply_op(input logic f, input logic w, input logic r,
                          input logic [KW-1:0] k, input logic [TW-1:0] t);
    flush = f; wrt = w; rd = r; key_in = k; tag_in = t;
    @(posedge clk); #1;
    flush = 0; wrt = 0; rd = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // kind 0: enqueue, 1: dequeue, 2: replace. Dequeue/replace assume a settled head.
  task automatic do_op(input int kind, input logic [KW-1:0] k, input logic [TW-1:0] t);
    bit eo [2];
    bit eu [2];
    int b;
    logic [KW+TW-1:0] exp;
    for (int s = 0; s < 2; s++) begin
      eo[s] = 0; eu[s] = 0;
      case (kind)
        0: if (mdl_n[s] == QS) eo[s] = 1; else mdl_add(s, k, t);
        1: if (mdl_n[s] == 0) eu[s] = 1;
           else begin
             b = best_idx(s);
             exp_q.push_back({mdl_key[s][b], mdl_tag[s][b]});
             mdl_vld[s][b] = 0;
             mdl_n[s]--;
           end
        default: if (mdl_n[s] == 0) mdl_add(s, k, t);
                 else begin
                   b = best_idx(s);
                   mdl_key[s][b] = k; mdl_tag[s][b] = t;
                 end
      endcase
    end
    if (kind == 1) begin
      for (int s = 0; s < 2; s++) begin
        if (!eu[s]) begin
          exp = exp_q.pop_front();
          n_vec++;
          if ({o_key[s], o_tag[s]} !== exp) begin
            n_err++;
            $display("FAIL pop[%0d]: got key/tag %h/%h required %h/%h",
                     s, o_key[s], o_tag[s], exp[KW+TW-1:TW], exp[TW-1:0]);
          end
        end
      end
    end
    apply_op(1'b0, kind != 1, kind != 0, k, t);
    for (int s = 0; s < 2; s++) begin
      n_vec++;
      if (o_ovf[s] !== eo[s] || o_udf[s] !== eu[s] || o_count[s] !== CW'(mdl_n[s])) begin
        n_err++;
        $display("FAIL op%0d[%0d]: got ovf/udf/count %b/%b/%0d required %b/%b/%0d",
                 kind, s, o_ovf[s], o_udf[s], o_count[s], eo[s], eu[s], mdl_n[s]);
      end
    end
  endtask

  task automatic settle_and_check(input string name);
    int cyc = 0;
    int b;
    while (!(o_set[0] && o_set[1]) && cyc < 32) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (!(o_set[0] && o_set[1])) begin
      n_err++;
      $display("FAIL %s settle: got o_settled %b%b required 11 within 32 cycles", name, o_set[0], o_set[1]);
    end
    for (int s = 0; s < 2; s++) begin
      n_vec++;
      if (o_count[s] !== CW'(mdl_n[s]) || o_hv[s] !== (mdl_n[s] > 0) ||
          o_empty[s] !== (mdl_n[s] == 0) || o_full[s] !== (mdl_n[s] == QS)) begin
        n_err++;
        $display("FAIL %s state[%0d]: got count/hv/empty/full %0d/%b/%b/%b required %0d/%b/%b/%b",
                 name, s, o_count[s], o_hv[s], o_empty[s], o_full[s],
                 mdl_n[s], mdl_n[s] > 0, mdl_n[s] == 0, mdl_n[s] == QS);
      end
      if (mdl_n[s] > 0) begin
        b = best_idx(s);
        n_vec++;
        if (o_key[s] !== mdl_key[s][b] || o_tag[s] !== mdl_tag[s][b]) begin
          n_err++;
          $display("FAIL %s head[%0d]: got %h/%h required %h/%h",
                   name, s, o_key[s], o_tag[s], mdl_key[s][b], mdl_tag[s][b]);
        end
      end
    end
  endtask

  task automatic check_reset_vals(input string name);
    logic [KW+TW+CW+5:0] got, req;
    for (int s = 0; s < 2; s++) begin
      got = {o_key[s], o_tag[s], o_hv[s], o_count[s], o_empty[s], o_full[s], o_ovf[s], o_udf[s], o_set[s]};
      req = {{KW{1'b0}}, {TW{1'b0}}, 1'b0, {CW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      n_vec++;
      if (got !== req) begin
        n_err++;
        $display("FAIL %s[%0d]: got {key,tag,hv,count,empty,full,ovf,udf,settled}=%h required %h",
                 name, s, got, req);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    check_reset_vals("reset");
  endtask

  task automatic test_enqueue_order();
    do_op(0, 16'd5, 8'hA);
    do_op(0, 16'd9, 8'hB);
    do_op(0, 16'd3, 8'hC);
    idle(6);
    n_vec++;
    if (o_key[0] !== 16'd9 || o_tag[0] !== 8'hB || o_count[0] !== 3'd3 || o_set[0] !== 1'b1) begin
      n_err++;
      $display("FAIL order_max: got %0d/%h count %0d settled %b required 9/0b count 3 settled 1",
               o_key[0], o_tag[0], o_count[0], o_set[0]);
    end
    n_vec++;
    if (o_key[1] !== 16'd3 || o_tag[1] !== 8'hC || o_count[1] !== 3'd3 || o_set[1] !== 1'b1) begin
      n_err++;
      $display("FAIL order_min: got %0d/%h count %0d settled %b required 3/0c count 3 settled 1",
               o_key[1], o_tag[1], o_count[1], o_set[1]);
    end
  endtask

  task automatic test_dequeue();
    do_op(1, '0, '0);
    settle_and_check("dequeue");
    n_vec++;
    if (o_key[0] !== 16'd5 || o_key[1] !== 16'd5) begin
      n_err++;
      $display("FAIL deq_head: got %0d,%0d required 5,5", o_key[0], o_key[1]);
    end
  endtask

  task automatic test_overflow();
    do_op(0, 16'd12, 8'h12);
    do_op(0, 16'd1, 8'h01);
    settle_and_check("fill");
    do_op(0, 16'd7, 8'h77);
    idle(1);
    n_vec++;
    if (o_ovf[0] !== 1'b0 || o_ovf[1] !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_pulse_len: got %b%b required 00", o_ovf[0], o_ovf[1]);
    end
    settle_and_check("after_ovf");
  endtask

  task automatic test_underflow();
    for (int i = 0; i < QS; i++) begin
      do_op(1, '0, '0);
      settle_and_check("drain");
    end
    do_op(1, '0, '0);
    idle(1);
    n_vec++;
    if (o_udf[0] !== 1'b0 || o_udf[1] !== 1'b0 || o_count[0] !== 3'd0) begin
      n_err++;
      $display("FAIL udf_pulse_len: got %b%b count %0d required 00 count 0", o_udf[0], o_udf[1], o_count[0]);
    end
  endtask

  task automatic test_zero_key();
    do_op(0, 16'd0, 8'h5A);
    for (int s = 0; s < 2; s++) begin
      n_vec++;
      if (o_hv[s] !== 1'b1 || o_key[s] !== 16'd0 || o_empty[s] !== 1'b0) begin
        n_err++;
        $display("FAIL zero_key[%0d]: got hv/key/empty %b/%0d/%b required 1/0/0", s, o_hv[s], o_key[s], o_empty[s]);
      end
    end
    settle_and_check("zero_key");
    do_op(1, '0, '0);
    do_op(2, 16'd4, 8'h44);
    for (int s = 0; s < 2; s++) begin
      n_vec++;
      if (o_key[s] !== 16'd4 || o_tag[s] !== 8'h44 || o_hv[s] !== 1'b1) begin
        n_err++;
        $display("FAIL repl_empty[%0d]: got key/tag/hv %0d/%h/%b required 4/44/1", s, o_key[s], o_tag[s], o_hv[s]);
      end
    end
    settle_and_check("repl_empty");
    do_op(1, '0, '0);
  endtask

  task automatic test_back_to_back();
    int nb;
    int kind;
    for (int r = 0; r < 4; r++) begin
      nb = $urandom_range(2, QS + 1);
      for (int i = 0; i < nb; i++) do_op(0, fresh_key(), TW'($urandom_range(0, 255)));
      settle_and_check("b2b_fill");
      for (int i = 0; i < 5; i++) begin
        kind = $urandom_range(1, 2);
        do_op(kind, fresh_key(), TW'($urandom_range(0, 255)));
        settle_and_check("b2b_mix");
      end
    end
    while (mdl_n[0] > 0) begin
      do_op(1, '0, '0);
      settle_and_check("b2b_drain");
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < QS; i++) do_op(0, fresh_key(), TW'($urandom_range(0, 255)));
    mdl_clear();
    apply_op(1'b1, 1'b1, 1'b0, fresh_key(), 8'hEE);
    for (int s = 0; s < 2; s++) begin
      n_vec++;
      if (o_count[s] !== 3'd0 || o_ovf[s] !== 1'b0 || o_empty[s] !== 1'b1 || o_hv[s] !== 1'b0) begin
        n_err++;
        $display("FAIL flush[%0d]: got count/ovf/empty/hv %0d/%b/%b/%b required 0/0/1/0",
                 s, o_count[s], o_ovf[s], o_empty[s], o_hv[s]);
      end
    end
    settle_and_check("flush");
  endtask

  task automatic test_async_reset();
    do_op(0, 16'd1, 8'h11);
    do_op(0, 16'd2, 8'h22);
    do_op(0, 16'd3, 8'h33);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    mdl_clear();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 0; wrt = 0; rd = 0; key_in = '0; tag_in = '0;
    mdl_clear();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_enqueue_order();
    test_dequeue();
    test_overflow();
    test_underflow();
    test_zero_key();
    test_back_to_back();
    test_flush();
    test_async_reset();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d expected pops left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
